// File: rtl/fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fetch_stage: PC owner, inst_mem port-A read driver, 2-entry IF/ID queue     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h275E_FBCF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_we,
   output logic [31:0] imem_wdata,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] c_depth = 2'd2;

   logic [31:0] pc_q, pc_d;
   logic [31:0] qpc_q [2];
   logic [31:0] qpc_d [2];
   logic [31:0] qinst_q [2];
   logic [31:0] qinst_d [2];
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        misalign_err_q, misalign_err_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic w_head_valid;
   logic w_pop;
   logic w_push;

   assign w_head_valid = (count_q != 2'd0);
   assign w_pop        = w_head_valid & id_ready;
   // A pop frees the slot in the same cycle, so a full queue still streams.
   assign w_push       = fetch_en & ~redirect_valid & ((count_q != c_depth) | w_pop);

   always_comb begin
      pc_d           = pc_q;
      qpc_d          = qpc_q;
      qinst_d        = qinst_q;
      count_d        = count_q;
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      misalign_err_d = misalign_err_q;
      fetch_count_d  = fetch_count_q;

      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_err_d = 1'b1;
         end
      end else begin
         if (w_push) begin
            qpc_d[wr_ptr_q]   = pc_q;
            qinst_d[wr_ptr_q] = imem_rdata;
            pc_d              = pc_q + 32'd4;
            wr_ptr_d          = ~wr_ptr_q;
            fetch_count_d     = fetch_count_q + 32'd1;
         end
         if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q           <= RESET_PC;
         qpc_q          <= '{default: '0};
         qinst_q        <= '{default: '0};
         count_q        <= 2'd0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         misalign_err_q <= 1'b0;
         fetch_count_q  <= 32'd0;
      end else begin
         pc_q           <= pc_d;
         qpc_q          <= qpc_d;
         qinst_q        <= qinst_d;
         count_q        <= count_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         misalign_err_q <= misalign_err_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

   assign imem_addr    = pc_q;
   assign imem_we      = 4'b0000;
   assign imem_wdata   = 32'h0;
   assign id_valid     = w_head_valid;
   assign id_inst      = w_head_valid ? qinst_q[rd_ptr_q] : NOP_INST;
   assign id_pc        = w_head_valid ? qpc_q[rd_ptr_q] : 32'h0;
   assign misalign_err = misalign_err_q;
   assign fetch_count  = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fetch_stage: vector table + reference-queue scoreboard for fetch_stage   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_fetch_stage;

   localparam logic [31:0] c_reset_pc = 32'h0000_0000;
   localparam logic [31:0] c_nop      = 32'h275E_FBCF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [3:0]  imem_we;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        misalign_err;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_we        (imem_we),
      .imem_wdata     (imem_wdata),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .misalign_err   (misalign_err),
      .fetch_count    (fetch_count)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0011;
         32'h4:   return 32'h0000_0022;
         32'h8:   return 32'h0000_0033;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign imem_rdata = mem(imem_addr);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: expected queue contents plus PC / counters.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] m_pc;
   logic [31:0] m_fc;
   logic        m_mis;

   task automatic model_reset();
      sb.delete();
      m_pc  = c_reset_pc;
      m_fc  = 32'h0;
      m_mis = 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      ev    = (sb.size() != 0);
      epc   = ev ? sb[0].pc : 32'h0;
      einst = ev ? sb[0].inst : c_nop;
      chk({tag, ".id_valid"}, {31'h0, id_valid}, {31'h0, ev});
      chk({tag, ".id_pc"}, id_pc, epc);
      chk({tag, ".id_inst"}, id_inst, einst);
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      chk({tag, ".fetch_count"}, fetch_count, m_fc);
      chk({tag, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, m_mis});
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      fetch_en       = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all("reset");
      chk("reset.imem_we", {28'h0, imem_we}, 32'h0);
      chk("reset.imem_wdata", imem_wdata, 32'h0);
   endtask

   // Drive one cycle, predict the edge in the model, then compare after it.
   task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc,
                       input string tag);
      bit          pop;
      bit          push;
      logic [31:0] inst;
      fetch_en       = fe;
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      pop  = (sb.size() != 0) && rdy;
      push = fe && !rv && ((sb.size() < 2) || pop);
      inst = mem(m_pc);
      @(posedge clk);
      #1;
      if (rv) begin
         sb.delete();
         m_pc = {rpc[31:2], 2'b00};
         if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            sb.push_back('{pc: m_pc, inst: inst});
            m_pc = m_pc + 32'd4;
            m_fc = m_fc + 32'd1;
         end
      end
      check_all(tag);
   endtask

   typedef struct {
      bit          do_rst;
      bit          fe;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          ev;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [31:0] eaddr;
      logic [31:0] efc;
      bit          emis;
   } vec_t;

   vec_t tv[$];

   task automatic add(input bit r, input bit fe, input bit rdy, input bit rv,
                      input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                      input logic [31:0] einst, input logic [31:0] eaddr,
                      input logic [31:0] efc, input bit emis);
      vec_t v;
      v.do_rst = r;   v.fe = fe;   v.rdy = rdy;   v.rv = rv;   v.rpc = rpc;
      v.ev = ev;      v.epc = epc; v.einst = einst; v.eaddr = eaddr;
      v.efc = efc;    v.emis = emis;
      tv.push_back(v);
   endtask

   initial begin
      // Streaming from reset
      add(1, 1, 1, 0, 32'h0,  1, 32'h0,  32'h11,        32'h4,  1, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'h4,  32'h22,        32'h8,  2, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'h8,  32'h33,        32'hC,  3, 0);
      // Back-pressure: fill, hold, then drain in order
      add(1, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h4,  1, 0);
      add(0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h8,  2, 0);
      add(0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h8,  2, 0);
      add(0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h8,  2, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'h4,  32'h22,        32'hC,  3, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'h8,  32'h33,        32'h10, 4, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'hC,  32'hC0DE000C,  32'h14, 5, 0);
      // Redirect from a full queue, then a misaligned redirect
      add(1, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h4,  1, 0);
      add(0, 1, 0, 0, 32'h0,  1, 32'h0,  32'h11,        32'h8,  2, 0);
      add(0, 1, 1, 1, 32'h40, 0, 32'h0,  c_nop,         32'h40, 2, 0);
      add(0, 1, 1, 0, 32'h0,  1, 32'h40, 32'hC0DE0040,  32'h44, 3, 0);
      add(0, 1, 1, 1, 32'h42, 0, 32'h0,  c_nop,         32'h40, 3, 1);
      add(0, 1, 1, 0, 32'h0,  1, 32'h40, 32'hC0DE0040,  32'h44, 4, 1);
      add(0, 1, 1, 0, 32'h0,  1, 32'h44, 32'hC0DE0044,  32'h48, 5, 1);
      // fetch_en low drains and holds PC; redirect still loads while disabled
      add(0, 0, 1, 0, 32'h0,  0, 32'h0,  c_nop,         32'h48, 5, 1);
      add(0, 0, 1, 0, 32'h0,  0, 32'h0,  c_nop,         32'h48, 5, 1);
      add(0, 1, 1, 0, 32'h0,  1, 32'h48, 32'hC0DE0048,  32'h4C, 6, 1);
      add(0, 0, 1, 1, 32'h80, 0, 32'h0,  c_nop,         32'h80, 6, 1);
      add(0, 1, 1, 0, 32'h0,  1, 32'h80, 32'hC0DE0080,  32'h84, 7, 1);

      model_reset();
      for (int i = 0; i < tv.size(); i++) begin
         string t;
         t = $sformatf("v%0d", i);
         if (tv[i].do_rst) do_reset();
         step(tv[i].fe, tv[i].rdy, tv[i].rv, tv[i].rpc, {t, ".sb"});
         chk({t, ".id_valid"}, {31'h0, id_valid}, {31'h0, tv[i].ev});
         chk({t, ".id_pc"}, id_pc, tv[i].epc);
         chk({t, ".id_inst"}, id_inst, tv[i].einst);
         chk({t, ".imem_addr"}, imem_addr, tv[i].eaddr);
         chk({t, ".fetch_count"}, fetch_count, tv[i].efc);
         chk({t, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, tv[i].emis});
      end

      // Asynchronous reset in the middle of a cycle with a full queue
      do_reset();
      step(1, 0, 1, 32'h6, "mr.redir");
      step(1, 0, 0, 32'h0, "mr.fill0");
      step(1, 0, 0, 32'h0, "mr.fill1");
      chk("mr.full_valid", {31'h0, id_valid}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr.async_valid", {31'h0, id_valid}, 32'h0);
      chk("mr.async_addr", imem_addr, c_reset_pc);
      chk("mr.async_inst", id_inst, c_nop);
      chk("mr.async_mis", {31'h0, misalign_err}, 32'h0);
      chk("mr.async_fc", fetch_count, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all("mr.release");
      step(1, 1, 0, 32'h0, "mr.first");
      chk("mr.first_pc", id_pc, c_reset_pc);

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         bit          rv;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 7) == 0);
         rpc = $urandom_range(0, 255);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv, rpc,
              $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that owns the program counter, drives the instruction-side port A of `inst_mem`, and hands fetched instructions to the IF/ID decode stage through a 2-entry queue with a valid/ready handshake. It absorbs decode back-pressure without refetching. It applies branch/jump redirects with a full queue flush. It sits between the PC-redirect logic of later stages and the `inst_mem` port-A read path.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (must be word-aligned)
- `NOP_INST`, 32'h275E_FBCF, instruction presented on `id_inst` while the queue is empty
- `clk`  in  1  single system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `fetch_en`  in  1  1 = fetching allowed; 0 = hold PC, no pushes (pops continue)
- `redirect_valid`  in  1  redirect request this cycle
- `redirect_pc`  in  32  redirect target
- `imem_addr`  out  32  to `inst_mem.addr_a`; equals current PC register
- `imem_we`  out  4  to `inst_mem.addr_a_start`; constant 4'b0000
- `imem_wdata`  out  32  to `inst_mem.addr_a_write`; constant 32'h0
- `imem_rdata`  in  32  from `inst_mem.addr_a_read` (combinational, same cycle as `imem_addr`)
- `id_valid`  out  1  queue head valid
- `id_ready`  in  1  decode accepts head this cycle
- `id_inst`  out  32  head instruction; `NOP_INST` when empty
- `id_pc`  out  32  head PC; 32'h0 when empty
- `misalign_err`  out  1  sticky: a redirect target had bits [1:0] != 0
- `fetch_count`  out  32  count of instructions pushed into the queue, wraps at 2^32

## Operation
- State: `pc` (32), queue of 2 entries {pc, inst}, `count` (0..2), read pointer, write pointer, `misalign_err`, `fetch_count`.
- `pop` = `id_valid & id_ready`.
- `push` = `fetch_en & ~redirect_valid & (count < 2 | pop)`.
- On push:
  - the entry {pc, imem_rdata} is written at the write pointer.
  - `pc <= pc + 4`, mod 2^32.
  - `fetch_count <= fetch_count + 1`.
- `count` next value:
  - `count + push - pop` when there is no redirect.
  - 0 on redirect.
- Pointers advance modulo 2 on push/pop respectively.
- Redirect (`redirect_valid=1`):
  - The queue is flushed: count 0, both pointers 0.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push this cycle.
  - A simultaneous pop still counts as accepted by decode, but has no effect on queue state.
  - If `redirect_pc[1:0] != 0`, `misalign_err <= 1`. It is cleared only by `rst`.
- Redirect has priority over `fetch_en`. While `fetch_en=0` a redirect still loads `pc`.
- Full with no pop: PC holds and `imem_addr` is stable. No instruction is lost or duplicated.
- Empty: `id_valid=0`, `id_inst=NOP_INST`, `id_pc=0`.
- Outputs `id_*` are combinational from the queue head. `imem_addr` is directly the `pc` register.

## Timing
- Reset values:
  - `pc=RESET_PC`, `imem_addr=RESET_PC`
  - `count=0`, `id_valid=0`, `id_inst=NOP_INST`, `id_pc=0`
  - `misalign_err=0`, `fetch_count=0`
  - `imem_we=0`, `imem_wdata=0`
- Reset takes effect immediately (asynchronously). Reset mid-operation discards queue contents and any pending redirect.
- Fetch latency: an instruction at PC X, pushed at edge N, is visible on `id_*` with `id_valid=1` after edge N.
- First valid after reset deassertion: the first rising edge with `fetch_en=1` pushes `RESET_PC`. `id_valid=1` follows immediately after that edge.
- Redirect asserted in cycle N:
  - after edge N: `imem_addr` = target and `id_valid=0`.
  - after edge N+1: `id_valid=1` with the target instruction.
- Sustained throughput: 1 instruction/cycle when `id_ready=1` continuously.
- Simultaneous push and pop at `count=2`: count stays 2, ordering is preserved.

## Test plan
- Reset, `fetch_en=1`, `id_ready=1`, memory words 0x11,0x22,0x33 at 0,4,8 -> `id_pc` 0,4,8 on consecutive cycles with matching `id_inst`; `fetch_count`=3 after 3 edges.
- `id_ready=0` for 4 cycles from reset -> `count` saturates at 2, `imem_addr` holds 8, then `id_ready=1` -> PCs 0,4,8 delivered in order with no gap or duplicate.
- Queue full (entries PC 0,4), redirect to 0x40 with `id_ready=1` -> next cycle `id_valid=0`, `imem_addr`=0x40; following cycle `id_pc`=0x40.
- Redirect to 0x42 -> `imem_addr`=0x40, `misalign_err`=1, and it stays 1 across later fetches until `rst`.
- `fetch_en=0` with queue empty -> `id_valid=0`, `id_inst`=0x275EFBCF, PC unchanged, `fetch_count` unchanged; re-enable -> fetch resumes from held PC.
- Assert `rst` mid-stream with `count=2` -> `id_valid` drops to 0 immediately and `imem_addr`=`RESET_PC`.
